handover_link: RTL and testbench
================================

// Module: handover_link
// PURPOSE
//  Buffered valid/ready channel between a sending agent (alice) and a receiving
//  agent (bob). Queues tokens from the sender, presents each to the receiver
//  with an 8-bit sequence tag, and converts the receiver's acceptance into the
//  one-cycle send_en pulse that drives the agent counter.
//  Sits directly upstream of the agent counter in the handover path.
// PARAMETERS
//  DATA_W  8  token payload width in bits
//  DEPTH   4  FIFO entries; power of two, >= 2
// PORTS
//  clk        in   1                   single clock, all logic on posedge
//  rst        in   1                   synchronous reset, active-high
//  link_en    in   1                   1 = link open, 0 = close/drain request
//  in_valid   in   1                   sender token valid
//  in_ready   out  1                   link accepts token this cycle
//  in_data    in   DATA_W              sender token
//  out_valid  out  1                   token available to receiver
//  out_ready  in   1                   receiver accepts token
//  out_data   out  DATA_W              head token
//  out_seq    out  8                   sequence tag of head token
//  send_en    out  1                   pulse = out_valid & out_ready (drives agent)
//  level      out  $clog2(DEPTH+1)     entries currently stored
//  state_o    out  2                   link_state_t, for debug/visibility
// BEHAVIOUR
//  - Reset: state DISABLED, level 0, out_valid 0, out_data 0, out_seq 0,
//    in_ready 0, send_en 0. Buffered tokens are discarded. Reset mid-transfer
//    aborts it with no send_en.
//  - FSM (registered):
//    DISABLED -> ACTIVE  when link_en=1
//    ACTIVE   -> DRAIN   when link_en=0
//    DRAIN    -> ACTIVE  when link_en=1 (takes priority)
//    DRAIN    -> DISABLED when level=0
//  - in_ready = (state==ACTIVE) && (level<DEPTH). The signal is combinational
//    from registered state only; there is no full-bypass.
//  - Push on in_valid & in_ready; pop on out_valid & out_ready.
//  - First-word fall-through: out_valid = (level!=0). A token pushed into an
//    empty link sets out_valid on the next cycle (latency 1).
//  - Simultaneous push and pop: level is unchanged and both complete. When full,
//    a push is refused even if a pop occurs in the same cycle.
//  - out_data/out_seq stay stable while out_valid & !out_ready.
//  - out_seq is an 8-bit counter incremented on each pop and wraps 255 -> 0.
//    It is cleared only by rst, so it matches the agent counter value.
//  - send_en is combinational (out_valid & out_ready), never asserted when out_valid=0.
//  - When out_valid=0, out_data holds its last value (0 after reset).
// CONFIGURATION
//  HANDOVER_LINK_PARITY_EN defined:
//  - Adds output port out_parity (1 bit), the even parity of the head token.
//    Parity is computed at push and stored alongside the token.
//  - FIFO width becomes DATA_W+1.
//  HANDOVER_LINK_PARITY_EN undefined:
//  - No port and no storage. All other behaviour is identical.
// STRUCTURE
//  - Package handover_pkg: SEQ_W=8; link_state_t enum {DISABLED=0, ACTIVE=1,
//    DRAIN=2}; default DATA_W/DEPTH constants.
//  - Sub-module handover_fifo: synchronous FWFT FIFO holding read/write
//    pointers with an extra wrap bit, plus the level count.
//  - FSM, sequence counter and send_en logic live in handover_link.
// TESTING
//  1) rst, link_en=1, push 0xA5 -> out_valid=1 next cycle, out_data=0xA5,
//     out_seq=0; out_ready=1 -> send_en for one cycle, then out_seq=1, level=0.
//  2) DEPTH=4, out_ready=0, push 5 tokens -> first 4 accepted, in_ready=0 at
//     level=4; 5th held by sender until a pop occurs.
//  3) Full FIFO, in_valid=1 & out_ready=1 for 8 cycles -> one transfer per cycle,
//     level stays 3/4, order preserved, no token lost.
//  4) 3 tokens queued, link_en=0 -> state DRAIN, in_ready=0, 3 pops delivered,
//     then state DISABLED with level=0.
//  5) 256 transfers -> out_seq wraps 255 -> 0 and the bench agent counter
//     equals out_seq at every pop.
//  6) rst asserted with 2 tokens queued -> next cycle level=0, out_valid=0,
//     out_seq=0, no send_en; with PARITY_EN, push 0x07 -> out_parity=1.

Source files
------------

// File: rtl/handover_pkg.sv
// Shared types and constants for the alice -> bob handover link.
package handover_pkg;

    localparam int SEQ_W          = 8;
    localparam int DATA_W_DEFAULT = 8;
    localparam int DEPTH_DEFAULT  = 4;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ACTIVE   = 2'd1,
        DRAIN    = 2'd2
    } link_state_t;

endpackage

// File: rtl/handover_fifo.sv
// Synchronous first-word-fall-through FIFO with wrap-bit pointers and a level count.
module handover_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [LW-1:0]    level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push;
    logic             do_pop;

    // Same slot index with differing wrap bits means the write side has lapped the read side.
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
    assign level_o = level_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/handover_link.sv
// Buffered valid/ready link from alice to bob with sequence tags and the send_en agent pulse.
// Optional HANDOVER_LINK_PARITY_EN stores even parity per token and exposes out_parity.
module handover_link
    import handover_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int DEPTH  = DEPTH_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       link_en,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_data,
    output logic [SEQ_W-1:0]           out_seq,
    output logic                       send_en,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [1:0]                 state_o
`ifdef HANDOVER_LINK_PARITY_EN
    ,
    output logic                       out_parity
`endif
);

    localparam int LW = $clog2(DEPTH + 1);
`ifdef HANDOVER_LINK_PARITY_EN
    localparam int FW = DATA_W + 1;
`else
    localparam int FW = DATA_W;
`endif

    link_state_t      state_q, state_d;
    logic [SEQ_W-1:0] seq_q;
    logic [FW-1:0]    last_q;
    logic [FW-1:0]    wdata;
    logic [FW-1:0]    head;
    logic [FW-1:0]    shown;
    logic [LW-1:0]    fifo_level;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

`ifdef HANDOVER_LINK_PARITY_EN
    assign wdata = {^in_data, in_data};
`else
    assign wdata = in_data;
`endif

    handover_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wdata),
        .rdata_o (head),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready  = (state_q == ACTIVE) && !fifo_full;
    assign out_valid = !fifo_empty;
    // A transfer coinciding with rst is aborted, so the agent never sees it.
    assign send_en   = out_valid && out_ready && !rst;
    assign push      = in_valid && in_ready;
    assign pop       = send_en;
    assign shown     = out_valid ? head : last_q;
    assign out_data  = shown[DATA_W-1:0];
    assign out_seq   = seq_q;
    assign level     = fifo_level;
    assign state_o   = state_q;
`ifdef HANDOVER_LINK_PARITY_EN
    assign out_parity = shown[DATA_W];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= DISABLED;
            seq_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            if (pop) begin
                seq_q  <= seq_q + 1'b1;
                last_q <= head;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DISABLED: if (link_en) state_d = ACTIVE;
            ACTIVE:   if (!link_en) state_d = DRAIN;
            DRAIN: begin
                if (link_en) begin
                    state_d = ACTIVE;
                end else if (fifo_empty) begin
                    state_d = DISABLED;
                end
            end
            default:  state_d = DISABLED;
        endcase
    end

endmodule

// File: tb/tb_handover_link.sv
// Directed self-checking bench for handover_link (define HANDOVER_LINK_PARITY_EN to cover parity).
module tb_handover_link;

    logic       clk = 1'b0;
    logic       rst;
    logic       link_en;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] out_seq;
    logic       send_en;
    logic [2:0] level;
    logic [1:0] state_o;
`ifdef HANDOVER_LINK_PARITY_EN
    logic       out_parity;
`endif

    int         passCount  = 0;
    int         checkCount = 0;
    logic [7:0] expSeq     = 8'd0;
    logic [7:0] q[$];

    handover_link #(.DATA_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .link_en   (link_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_seq   (out_seq),
        .send_en   (send_en),
        .level     (level),
        .state_o   (state_o)
`ifdef HANDOVER_LINK_PARITY_EN
        ,
        .out_parity(out_parity)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; link_en = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkCount++; if (state_o !== 2'd0) $display("[TB] FAIL reset_state got %0d expected 0", state_o); else passCount++;
        checkCount++; if (level !== 3'd0) $display("[TB] FAIL reset_level got %0d expected 0", level); else passCount++;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %0b expected 0", out_valid); else passCount++;
        checkCount++; if (out_data !== 8'h00) $display("[TB] FAIL reset_out_data got %0h expected 0", out_data); else passCount++;
        checkCount++; if (out_seq !== 8'h00) $display("[TB] FAIL reset_out_seq got %0d expected 0", out_seq); else passCount++;
        checkCount++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got %0b expected 0", in_ready); else passCount++;
        checkCount++; if (send_en !== 1'b0) $display("[TB] FAIL reset_send_en got %0b expected 0", send_en); else passCount++;
    endtask

    task automatic test_single();
        link_en = 1'b1;
        tick();
        checkCount++; if (state_o !== 2'd1) $display("[TB] FAIL single_state got %0d expected 1", state_o); else passCount++;
        checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL single_in_ready got %0b expected 1", in_ready); else passCount++;
        in_valid = 1'b1; in_data = 8'hA5;
        tick();
        in_valid = 1'b0;
        #1;
        checkCount++; if (out_valid !== 1'b1) $display("[TB] FAIL single_out_valid got %0b expected 1", out_valid); else passCount++;
        checkCount++; if (out_data !== 8'hA5) $display("[TB] FAIL single_out_data got %0h expected a5", out_data); else passCount++;
        checkCount++; if (out_seq !== 8'd0) $display("[TB] FAIL single_out_seq got %0d expected 0", out_seq); else passCount++;
        checkCount++; if (level !== 3'd1) $display("[TB] FAIL single_level got %0d expected 1", level); else passCount++;
        out_ready = 1'b1;
        #1;
        checkCount++; if (send_en !== 1'b1) $display("[TB] FAIL single_send_en got %0b expected 1", send_en); else passCount++;
        tick();
        out_ready = 1'b0;
        expSeq = 8'd1;
        #1;
        checkCount++; if (send_en !== 1'b0) $display("[TB] FAIL single_send_en_end got %0b expected 0", send_en); else passCount++;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL single_empty got %0b expected 0", out_valid); else passCount++;
        checkCount++; if (out_seq !== expSeq) $display("[TB] FAIL single_seq_after got %0d expected %0d", out_seq, expSeq); else passCount++;
        checkCount++; if (level !== 3'd0) $display("[TB] FAIL single_level_after got %0d expected 0", level); else passCount++;
        checkCount++; if (out_data !== 8'hA5) $display("[TB] FAIL single_data_hold got %0h expected a5", out_data); else passCount++;
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h10 + i);
            #1;
            checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL full_accept%0d got %0b expected 1", i, in_ready); else passCount++;
            tick();
        end
        in_data = 8'h14;
        #1;
        checkCount++; if (in_ready !== 1'b0) $display("[TB] FAIL full_refuse got %0b expected 0", in_ready); else passCount++;
        checkCount++; if (level !== 3'd4) $display("[TB] FAIL full_level got %0d expected 4", level); else passCount++;
        tick();
        checkCount++; if (level !== 3'd4) $display("[TB] FAIL full_level_hold got %0d expected 4", level); else passCount++;
        checkCount++; if (out_data !== 8'h10) $display("[TB] FAIL full_head got %0h expected 10", out_data); else passCount++;
        out_ready = 1'b1;
        #1;
        checkCount++; if (in_ready !== 1'b0) $display("[TB] FAIL full_refuse_on_pop got %0b expected 0", in_ready); else passCount++;
        checkCount++; if (send_en !== 1'b1) $display("[TB] FAIL full_pop_send_en got %0b expected 1", send_en); else passCount++;
        tick();
        out_ready = 1'b0;
        expSeq = 8'd2;
        #1;
        checkCount++; if (level !== 3'd3) $display("[TB] FAIL full_level_after_pop got %0d expected 3", level); else passCount++;
        checkCount++; if (out_data !== 8'h11) $display("[TB] FAIL full_head_after_pop got %0h expected 11", out_data); else passCount++;
        checkCount++; if (out_seq !== expSeq) $display("[TB] FAIL full_seq got %0d expected %0d", out_seq, expSeq); else passCount++;
        checkCount++; if (in_ready !== 1'b1) $display("[TB] FAIL full_ready_again got %0b expected 1", in_ready); else passCount++;
        tick();
        in_valid = 1'b0;
        #1;
        checkCount++; if (level !== 3'd4) $display("[TB] FAIL full_fifth_stored got %0d expected 4", level); else passCount++;
        q = '{8'h11, 8'h12, 8'h13, 8'h14};
    endtask

    task automatic test_back_to_back();
        logic [7:0] nextTok;
        logic       expReady;
        nextTok = 8'h20;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; in_data = nextTok; out_ready = 1'b1;
            #1;
            expReady = (q.size() < 4);
            checkCount++; if (in_ready !== expReady) $display("[TB] FAIL b2b_ready%0d got %0b expected %0b", c, in_ready, expReady); else passCount++;
            checkCount++; if (out_data !== q[0]) $display("[TB] FAIL b2b_data%0d got %0h expected %0h", c, out_data, q[0]); else passCount++;
            checkCount++; if (out_seq !== expSeq) $display("[TB] FAIL b2b_seq%0d got %0d expected %0d", c, out_seq, expSeq); else passCount++;
            checkCount++; if (send_en !== 1'b1) $display("[TB] FAIL b2b_send_en%0d got %0b expected 1", c, send_en); else passCount++;
            tick();
            void'(q.pop_front());
            expSeq++;
            if (expReady) begin
                q.push_back(nextTok);
                nextTok++;
            end
            checkCount++; if (int'(level) !== q.size()) $display("[TB] FAIL b2b_level%0d got %0d expected %0d", c, level, q.size()); else passCount++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_drain();
        link_en = 1'b0;
        tick();
        checkCount++; if (state_o !== 2'd2) $display("[TB] FAIL drain_state got %0d expected 2", state_o); else passCount++;
        checkCount++; if (in_ready !== 1'b0) $display("[TB] FAIL drain_in_ready got %0b expected 0", in_ready); else passCount++;
        checkCount++; if (level !== 3'd3) $display("[TB] FAIL drain_level got %0d expected 3", level); else passCount++;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkCount++; if (send_en !== 1'b1) $display("[TB] FAIL drain_send_en%0d got %0b expected 1", k, send_en); else passCount++;
            checkCount++; if (out_data !== q[0]) $display("[TB] FAIL drain_data%0d got %0h expected %0h", k, out_data, q[0]); else passCount++;
            tick();
            void'(q.pop_front());
            expSeq++;
        end
        out_ready = 1'b0;
        #1;
        checkCount++; if (level !== 3'd0) $display("[TB] FAIL drain_level_end got %0d expected 0", level); else passCount++;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL drain_out_valid got %0b expected 0", out_valid); else passCount++;
        checkCount++; if (state_o !== 2'd2) $display("[TB] FAIL drain_still got %0d expected 2", state_o); else passCount++;
        tick();
        checkCount++; if (state_o !== 2'd0) $display("[TB] FAIL drain_disabled got %0d expected 0", state_o); else passCount++;
    endtask

    task automatic test_seq_wrap();
        logic [7:0] agentCount;
        int         modelLevel;
        agentCount = expSeq;
        modelLevel = 0;
        link_en = 1'b1;
        tick();
        for (int c = 0; c < 257; c++) begin
            in_valid = 1'b1; in_data = 8'(c); out_ready = 1'b1;
            #1;
            checkCount++; if (send_en !== (modelLevel != 0)) $display("[TB] FAIL wrap_send_en%0d got %0b expected %0b", c, send_en, modelLevel != 0); else passCount++;
            if (modelLevel != 0) begin
                checkCount++; if (out_seq !== agentCount) $display("[TB] FAIL wrap_seq%0d got %0d expected %0d", c, out_seq, agentCount); else passCount++;
                checkCount++; if (out_data !== 8'(c - 1)) $display("[TB] FAIL wrap_data%0d got %0h expected %0h", c, out_data, 8'(c - 1)); else passCount++;
            end
            tick();
            if (modelLevel != 0) agentCount++;
            else modelLevel = 1;
        end
        in_valid = 1'b0;
        #1;
        checkCount++; if (send_en !== 1'b1) $display("[TB] FAIL wrap_last_send_en got %0b expected 1", send_en); else passCount++;
        tick();
        agentCount++;
        out_ready = 1'b0;
        checkCount++; if (level !== 3'd0) $display("[TB] FAIL wrap_level got %0d expected 0", level); else passCount++;
        checkCount++; if (out_seq !== agentCount) $display("[TB] FAIL wrap_final_seq got %0d expected %0d", out_seq, agentCount); else passCount++;
        expSeq = agentCount;
    endtask

    task automatic test_reset_mid();
        in_valid = 1'b1; in_data = 8'h31;
        tick();
        in_data = 8'h32;
        tick();
        in_valid = 1'b0;
        checkCount++; if (level !== 3'd2) $display("[TB] FAIL rstmid_level_before got %0d expected 2", level); else passCount++;
        rst = 1'b1; out_ready = 1'b1;
        #1;
        checkCount++; if (send_en !== 1'b0) $display("[TB] FAIL rstmid_send_en_during got %0b expected 0", send_en); else passCount++;
        tick();
        rst = 1'b0;
        #1;
        checkCount++; if (level !== 3'd0) $display("[TB] FAIL rstmid_level got %0d expected 0", level); else passCount++;
        checkCount++; if (out_valid !== 1'b0) $display("[TB] FAIL rstmid_out_valid got %0b expected 0", out_valid); else passCount++;
        checkCount++; if (out_seq !== 8'd0) $display("[TB] FAIL rstmid_out_seq got %0d expected 0", out_seq); else passCount++;
        checkCount++; if (send_en !== 1'b0) $display("[TB] FAIL rstmid_send_en got %0b expected 0", send_en); else passCount++;
        checkCount++; if (out_data !== 8'h00) $display("[TB] FAIL rstmid_out_data got %0h expected 0", out_data); else passCount++;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b1; in_data = 8'h07;
        tick();
        in_valid = 1'b0;
        checkCount++; if (out_data !== 8'h07) $display("[TB] FAIL rstmid_repush got %0h expected 07", out_data); else passCount++;
`ifdef HANDOVER_LINK_PARITY_EN
        checkCount++; if (out_parity !== 1'b1) $display("[TB] FAIL parity_07 got %0b expected 1", out_parity); else passCount++;
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_drain();
        test_seq_wrap();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
